// File: rtl/mio_bus_bridge.sv
// Memory/IO bridge between the multi-cycle CPU core and its targets: block RAM,
// a switch/LED GPIO port and a free-running 32-bit counter, with per-target wait states.
module mio_bus_bridge #(
  parameter int RAM_AW   = 10,
  parameter int RAM_WAIT = 1,
  parameter int IO_WAIT  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              mem_w,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       data_from_cpu,
  output logic [31:0]       data_to_cpu,
  output logic              mio_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [7:0]        led_out
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  typedef enum logic [1:0] {T_RAM, T_GPIO, T_CNT, T_NONE} target_t;

  localparam logic [31:0] GPIO_ADDR  = 32'hE000_0000;
  localparam logic [31:0] CNT_ADDR   = 32'hF000_0000;
  localparam logic [7:0]  RAM_WAIT_W = 8'(RAM_WAIT);
  localparam logic [7:0]  IO_WAIT_W  = 8'(IO_WAIT);

  state_t      state;
  logic [7:0]  wcnt;
  logic [29:0] lat_waddr;
  logic        lat_w;
  logic [31:0] lat_data;
  logic [31:0] count;
  logic [31:0] rd_data;
  target_t     tgt;
  logic        commit;

  // Byte-lane bits never take part in decode; all accesses are whole words.
  logic unused_byte_lane;
  assign unused_byte_lane = &{1'b0, addr_in[1:0]};

  function automatic target_t decode(input logic [29:0] wa);
    if (wa[29:RAM_AW] == '0)           return T_RAM;
    else if (wa == GPIO_ADDR[31:2])    return T_GPIO;
    else if (wa == CNT_ADDR[31:2])     return T_CNT;
    else                               return T_NONE;
  endfunction

  assign tgt      = decode(lat_waddr);
  assign commit   = (state == S_WAIT) && (wcnt == 8'd0);
  assign ram_addr = lat_waddr[RAM_AW-1:0];
  assign ram_din  = lat_data;
  assign ram_we   = !reset && commit && lat_w && (tgt == T_RAM);

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_data = 32'd0;
    unique case (tgt)
      T_RAM:   rd_data = ram_dout;
      T_GPIO:  rd_data = {16'd0, sw_in};
      T_CNT:   rd_data = count;
      default: rd_data = 32'd0;
    endcase
  end

  // A commit-cycle write wins over the increment for that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 32'd0;
    end else if (commit && lat_w && (tgt == T_CNT)) begin
      count <= lat_data;
    end else begin
      count <= count + 32'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, matching the hardware.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wcnt        <= 8'd0;
      lat_waddr   <= 30'd0;
      lat_w       <= 1'b0;
      lat_data    <= 32'd0;
      mio_ready   <= 1'b0;
      data_to_cpu <= 32'd0;
      led_out     <= 8'd0;
    end else begin
      mio_ready <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cpu_req) begin
            lat_waddr <= addr_in[31:2];
            lat_w     <= mem_w;
            lat_data  <= data_from_cpu;
            wcnt      <= (decode(addr_in[31:2]) == T_RAM) ? RAM_WAIT_W : IO_WAIT_W;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wcnt != 8'd0) begin
            wcnt <= wcnt - 8'd1;
          end else begin
            if (!lat_w) begin
              data_to_cpu <= rd_data;
            end else if (tgt == T_GPIO) begin
              led_out <= lat_data[7:0];
            end
            mio_ready <= 1'b1;
            state     <= S_ACK;
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_bridge.sv
// Scoreboard bench for mio_bus_bridge: stimulus pushes expected read data and ready cycle,
// monitors pop on each mio_ready pulse. A second instance covers a longer RAM wait.
module tb_mio_bus_bridge;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_init;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  // Main instance: RAM_WAIT=1, IO_WAIT=0
  logic        cpu_req, mem_w;
  logic [31:0] addr_in, data_from_cpu, data_to_cpu, ram_din, ram_dout;
  logic        mio_ready, ram_we;
  logic [9:0]  ram_addr;
  logic [15:0] sw_in;
  logic [7:0]  led_out;

  // Second instance: RAM_WAIT=3
  logic        req3, w3;
  logic [31:0] addr3, din3, dout3, ramdin3, ramdout3;
  logic        ready3, we3;
  logic [9:0]  ramaddr3;
  logic [15:0] sw3;
  logic [7:0]  led3;

  logic [31:0] mem  [0:1023];
  logic [31:0] mem3 [0:1023];

  exp_t        sb[$];
  exp_t        sb3[$];
  exp_t        mon_e, mon_e3;
  int          we_cnt = 0;
  logic [9:0]  last_we_addr;
  logic [31:0] last_we_din;
  logic [31:0] last_rd;
  logic [31:0] cnt_val0;
  int          cnt_cyc0;

  mio_bus_bridge #(.RAM_AW(10), .RAM_WAIT(1), .IO_WAIT(0)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .mem_w(mem_w), .addr_in(addr_in),
    .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu), .mio_ready(mio_ready),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .sw_in(sw_in), .led_out(led_out)
  );

  mio_bus_bridge #(.RAM_AW(10), .RAM_WAIT(3), .IO_WAIT(0)) dut3 (
    .clk(clk), .reset(reset), .cpu_req(req3), .mem_w(w3), .addr_in(addr3),
    .data_from_cpu(din3), .data_to_cpu(dout3), .mio_ready(ready3),
    .ram_addr(ramaddr3), .ram_we(we3), .ram_din(ramdin3), .ram_dout(ramdout3),
    .sw_in(sw3), .led_out(led3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int idx);
    return 32'h5A00_0000 | 32'(idx);
  endfunction

  // Synchronous-read RAM models
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem3[i] <= init_val(i);
    end else if (we3) begin
      mem3[ramaddr3] <= ramdin3;
    end
    ramdout3 <= mem3[ramaddr3];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strobe monitor
  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= ram_addr;
      last_we_din  <= ram_din;
    end
  end

  // Response monitors
  always @(negedge clk) begin
    if (!reset && mio_ready) begin
      if (sb.size() == 0) begin
        check("spurious_ready", 32'(mio_ready), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rd_data", data_to_cpu, mon_e.data);
        check("ready_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ready3) begin
      if (sb3.size() == 0) begin
        check("spurious_ready3", 32'(ready3), 32'd0);
      end else begin
        mon_e3 = sb3.pop_front();
        check("rd_data3", dout3, mon_e3.data);
        check("ready_cycle3", 32'(cyc), 32'(mon_e3.cyc));
      end
    end
  end

  task automatic finish_txn(input int base, input int exp_strobes);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      got = mio_ready;
    end
    check("ready_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    check("strobe_count", 32'(we_cnt - base), 32'(exp_strobes));
  endtask

  // Issues one transaction, scrambles the inputs once it is taken, and waits for completion.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd_exp, input int lat, input int exp_strobes);
    int base;
    base          = we_cnt;
    cpu_req       = 1'b1;
    mem_w         = w;
    addr_in       = a;
    data_from_cpu = d;
    if (!w) last_rd = rd_exp;
    sb.push_back('{data: last_rd, cyc: cyc + lat});
    @(posedge clk); #1;
    cpu_req       = 1'b0;
    mem_w         = ~w;
    addr_in       = ~a;
    data_from_cpu = ~d;
    finish_txn(base, exp_strobes);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, base;
    logic [31:0] e;
    reset = 1'b1; mem_init = 1'b1;
    cpu_req = 1'b0; mem_w = 1'b0; addr_in = 32'd0; data_from_cpu = 32'd0;
    req3 = 1'b0; w3 = 1'b0; addr3 = 32'd0; din3 = 32'd0; sw3 = 16'h0F0F;
    sw_in = 16'hA5C3;
    last_rd = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data_to_cpu, 32'd0);
    check("rst_ready", 32'(mio_ready), 32'd0);
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    mem_init = 1'b0;
    reset    = 1'b0;
    @(posedge clk); #1;

    // RAM write then read, both complete in cycle 3
    run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 3, 1);
    check("we_addr", 32'(last_we_addr), 32'd4);
    check("we_din", last_we_din, 32'hDEAD_BEEF);
    run_txn(1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 3, 0);

    // GPIO read (low address bits ignored) and LED write
    run_txn(1'b0, 32'hE000_0000, 32'd0, 32'h0000_A5C3, 2, 0);
    sw_in = 16'h3C5A;
    run_txn(1'b0, 32'hE000_0003, 32'd0, 32'h0000_3C5A, 2, 0);
    run_txn(1'b1, 32'hE000_0000, 32'h1234_5678, 32'd0, 2, 0);
    check("led_write", 32'(led_out), 32'h78);

    // Counter load near the top, then reads that straddle the wrap
    c = cyc;
    run_txn(1'b1, 32'hF000_0000, 32'hFFFF_FFFE, 32'd0, 2, 0);
    cnt_val0 = 32'hFFFF_FFFE;
    cnt_cyc0 = c + 2;
    c = cyc;
    e = cnt_val0 + 32'(c + 1 - cnt_cyc0);
    run_txn(1'b0, 32'hF000_0000, 32'd0, e, 2, 0);
    check("cnt_wrap", data_to_cpu, 32'h0000_0000);
    repeat (5) @(posedge clk);
    #1;
    c = cyc;
    e = cnt_val0 + 32'(c + 1 - cnt_cyc0);
    run_txn(1'b0, 32'hF000_0000, 32'd0, e, 2, 0);

    // Unmapped accesses, including the first address past RAM
    run_txn(1'b0, 32'h8000_0000, 32'd0, 32'd0, 2, 0);
    run_txn(1'b1, 32'h8000_0000, 32'hCAFE_F00D, 32'd0, 2, 0);
    check("led_unmapped", 32'(led_out), 32'h78);
    c = cyc;
    e = cnt_val0 + 32'(c + 1 - cnt_cyc0);
    run_txn(1'b0, 32'hF000_0000, 32'd0, e, 2, 0);
    run_txn(1'b1, 32'h0000_1000, 32'h1111_1111, 32'd0, 2, 0);
    run_txn(1'b0, 32'h0000_0000, 32'd0, init_val(0), 3, 0);
    run_txn(1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 3, 0);
    run_txn(1'b1, 32'h0000_0FFC, 32'h7E7E_7E7E, 32'd0, 3, 1);
    check("we_addr_top", 32'(last_we_addr), 32'h3FF);
    run_txn(1'b0, 32'h0000_0FFC, 32'd0, 32'h7E7E_7E7E, 3, 0);

    // Reset during the wait state of a RAM write, with a request held through reset
    base          = we_cnt;
    cpu_req       = 1'b1;
    mem_w         = 1'b1;
    addr_in       = 32'h0000_0020;
    data_from_cpu = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    check("we_in_wait", 32'(ram_we), 32'd0);
    reset   = 1'b1;
    mem_w   = 1'b0;
    addr_in = 32'hE000_0000;
    @(posedge clk); #1;
    check("rrst_ready", 32'(mio_ready), 32'd0);
    check("rrst_we", 32'(ram_we), 32'd0);
    check("rrst_data", data_to_cpu, 32'd0);
    check("rrst_led", 32'(led_out), 32'd0);
    check("rrst_addr", 32'(ram_addr), 32'd0);
    check("rrst_din", ram_din, 32'd0);
    @(posedge clk); #1;
    reset   = 1'b0;
    last_rd = 32'h0000_3C5A;
    sb.push_back('{data: last_rd, cyc: cyc + 2});
    @(posedge clk); #1;
    cpu_req = 1'b0;
    finish_txn(base, 0);
    run_txn(1'b0, 32'h0000_0020, 32'd0, init_val(8), 3, 0);

    // Back-to-back reads on the RAM_WAIT=3 instance
    c     = cyc;
    req3  = 1'b1;
    w3    = 1'b0;
    addr3 = 32'h0000_0040;
    sb3.push_back('{data: init_val(16), cyc: c + 5});
    sb3.push_back('{data: init_val(33), cyc: c + 11});
    repeat (6) @(posedge clk);
    #1;
    addr3 = 32'h0000_0084;
    @(posedge clk); #1;
    req3  = 1'b0;
    addr3 = 32'hFFFF_FFFF;
    for (int i = 0; i < 40 && sb3.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("sb3_drained", 32'(sb3.size()), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
